// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the fetch front end.
// Holds the fetch FIFO entry layout used by inst_fetch and fetch_fifo.
package riscv_pkg;

   localparam int          XLEN        = 32;
   localparam int          IMEM_ADDR_W = 10;
   localparam logic [31:0] RESET_PC    = 32'h0000_0000;
   localparam logic [31:0] NOP         = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry buffer of {pc, instr} between fetch and decode.
// Registered storage, power-of-two pointers, synchronous flush.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [CW-1:0] count
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          empty;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full && !pop));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(pop && empty));

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: owns the PC, issues one inst_mem read per cycle and feeds
// decode through fetch_fifo; a redirect flushes and restarts the stream.
module inst_fetch
   import riscv_pkg::*;
#(
   parameter int          ADDR_W   = IMEM_ADDR_W,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_ren,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [31:0]       if_instr,
   output logic [31:0]       if_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc;
   logic [31:0]   infl_pc;
   logic          inflight;
   logic [CW-1:0] count;
   logic [CW:0]   occ;
   logic          pop;
   logic          push;
   logic          issue;
   fetch_entry_t  push_data;
   fetch_entry_t  head;

   assign if_valid  = (count != '0);
   assign pop       = if_valid & if_ready;
   assign push      = inflight & ~redirect_valid;
   assign push_data = '{pc: infl_pc, instr: imem_rdata};

   // Slots already committed after this cycle's pop; never issue past DEPTH.
   assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign issue = rst_n & ~redirect_valid & (occ < (CW+1)'(DEPTH));

   assign imem_ren  = issue;
   assign imem_addr = fetch_pc[ADDR_W+1:2];
   assign if_instr  = if_valid ? head.instr : '0;
   assign if_pc     = if_valid ? head.pc    : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         infl_pc  <= '0;
         inflight <= 1'b0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc & ~32'd3;
         inflight <= 1'b0;
      end else if (issue) begin
         fetch_pc <= fetch_pc + 32'd4;
         infl_pc  <= fetch_pc;
         inflight <= 1'b1;
      end else begin
         inflight <= 1'b0;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with an inst_mem model
// preloaded as mem[i] = 32'h1000_0000 + i.
module tb_inst_fetch;

   localparam int AW = 10;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] imem_addr;
   logic          imem_ren;
   logic [31:0]   imem_rdata;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          if_valid;
   logic          if_ready;
   logic [31:0]   if_instr;
   logic [31:0]   if_pc;

   int errors = 0;
   int checks = 0;

   inst_fetch #(.ADDR_W(AW), .DEPTH(2), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_ren       (imem_ren),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial imem_rdata = '0;
   always @(posedge clk)
      if (imem_ren) imem_rdata <= 32'h1000_0000 + {22'b0, imem_addr};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] pc);
      return 32'h1000_0000 + {22'b0, pc[11:2]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic head(input string tag, input logic [31:0] pc);
      chk({tag, ".valid"}, {31'b0, if_valid}, 32'd1);
      chk({tag, ".pc"}, if_pc, pc);
      chk({tag, ".instr"}, if_instr, word_of(pc));
   endtask

   task automatic empty(input string tag);
      chk({tag, ".valid"}, {31'b0, if_valid}, 32'd0);
   endtask

   task automatic issue(input string tag, input logic [AW-1:0] a);
      chk({tag, ".ren"}, {31'b0, imem_ren}, 32'd1);
      chk({tag, ".addr"}, {22'b0, imem_addr}, {22'b0, a});
   endtask

   task automatic start_from_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      issue({tag, ".c0"}, 10'd0);
      empty({tag, ".c0"});
      tick();
      issue({tag, ".c1"}, 10'd1);
      empty({tag, ".c1"});
      tick();
      head({tag, ".c2"}, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      if_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      tick();
      tick();
      chk("rst.valid", {31'b0, if_valid}, 32'd0);
      chk("rst.ren", {31'b0, imem_ren}, 32'd0);
      chk("rst.instr", if_instr, 32'd0);
      chk("rst.pc", if_pc, 32'd0);

      // 1: reset release, streaming
      start_from_reset("t1");
      for (int k = 1; k <= 3; k++) begin
         tick();
         head("t1.seq", 32'(4 * k));
      end

      // 2: backpressure for 5 cycles with head 0x10
      tick();
      if_ready = 1'b0;
      #1;
      head("t2.hold0", 32'h10);
      chk("t2.ren_drop", {31'b0, imem_ren}, 32'd0);
      for (int k = 1; k < 5; k++) begin
         tick();
         head("t2.hold", 32'h10);
         chk("t2.ren_off", {31'b0, imem_ren}, 32'd0);
      end
      tick();
      if_ready = 1'b1;
      #1;
      head("t2.rel", 32'h10);
      issue("t2.rel", 10'd6);
      for (int k = 0; k < 3; k++) begin
         tick();
         head("t2.cont", 32'(32'h14 + 4 * k));
      end

      // 3: redirect to 0x43 with one buffered and one in flight
      tick();
      if_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h43;
      #1;
      head("t3.r", 32'h20);
      chk("t3.r.ren", {31'b0, imem_ren}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      if_ready = 1'b1;
      #1;
      empty("t3.r1");
      issue("t3.r1", 10'h10);
      tick();
      empty("t3.r2");
      tick();
      head("t3.r3", 32'h40);
      tick();
      head("t3.r4", 32'h44);

      // 4: redirect in the same cycle as a pop
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      #1;
      head("t4.pop", 32'h48);
      tick();
      redirect_valid = 1'b0;
      #1;
      empty("t4.r1");
      tick();
      empty("t4.r2");
      tick();
      head("t4.r3", 32'h100);

      // 5: address wrap of inst_mem
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFF8;
      #1;
      head("t5.pop", 32'h104);
      tick();
      redirect_valid = 1'b0;
      #1;
      issue("t5.a0", 10'd1022);
      tick();
      issue("t5.a1", 10'd1023);
      tick();
      issue("t5.a2", 10'd0);
      head("t5.h0", 32'hFF8);
      tick();
      head("t5.h1", 32'hFFC);
      tick();
      head("t5.h2", 32'h1000);

      // PC wrap at the top of the address space, redirect held 3 cycles
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      tick();
      redirect_pc = 32'hFFFF_FFFE;
      tick();
      #1;
      chk("t7.held.ren", {31'b0, imem_ren}, 32'd0);
      empty("t7.held");
      tick();
      redirect_valid = 1'b0;
      #1;
      issue("t7.r1", 10'h3FF);
      tick();
      tick();
      head("t7.h0", 32'hFFFF_FFFC);
      tick();
      head("t7.h1", 32'h0);

      // 6: asynchronous reset mid-stream
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6.valid", {31'b0, if_valid}, 32'd0);
      chk("t6.ren", {31'b0, imem_ren}, 32'd0);
      chk("t6.instr", if_instr, 32'd0);
      tick();
      start_from_reset("t6");
      tick();
      head("t6.c3", 32'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
